// File: rtl/timer_bank_pkg.sv
// timer_bank shared definitions: register offsets, CTRL bits,
// and prescaler divider-select tables.
package timer_bank_pkg;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_SCALE = 3'd1;
  localparam logic [2:0] REG_PRE_L = 3'd2;
  localparam logic [2:0] REG_PRE_H = 3'd3;
  localparam logic [2:0] REG_CMP_L = 3'd4;
  localparam logic [2:0] REG_CMP_H = 3'd5;
  localparam logic [2:0] REG_CNT_L = 3'd6;
  localparam logic [2:0] REG_CNT_H = 3'd7;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_SRC     = 3;
  localparam int CTRL_CASC    = 4;

  // number of low prescaler bits that must be all ones per select
  localparam int CORE_BITS [8] = '{1, 3, 5, 6, 7, 8, 10, 12};
  localparam int RTC_BITS  [8] = '{0, 1, 2, 3, 4, 5, 6, 7};

  function automatic logic [11:0] core_mask(input logic [2:0] sel);
    return 12'((1 << CORE_BITS[sel]) - 1);
  endfunction

  function automatic logic [6:0] rtc_mask(input logic [2:0] sel);
    return 7'((1 << RTC_BITS[sel]) - 1);
  endfunction

endpackage

// File: rtl/timer_bank_ch.sv
// timer_bank_ch: one down-counting timer channel with its registers.
// Cascade input exists only when TIMER_BANK_CASCADE_EN is defined.
module timer_bank_ch
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef TIMER_BANK_CASCADE_EN
  , parameter int IDX = 0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_ce,
  input  logic       we_i,
  input  logic       re_i,
  input  logic [2:0] reg_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] core_tick_i,
  input  logic [7:0] rtc_tick_i,
`ifdef TIMER_BANK_CASCADE_EN
  input  logic       casc_i,
`endif
  output logic [7:0] rdata_o,
  output logic       under_o,
  output logic       cmp_o
);

  logic en_q, en_d;
  logic rl_q, rl_d;
  logic os_q, os_d;
  logic src_q, src_d;
  logic casc_rd;
`ifdef TIMER_BANK_CASCADE_EN
  logic casc_q, casc_d;
`endif
  logic [2:0] scale_q, scale_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] snap_q, snap_d;
  logic und_q, und_d;
  logic cmpi_q, cmpi_d;
  logic tick;
  logic [15:0] pre16, cmp16, cnt16;
  logic [15:0] wide;

  assign pre16 = 16'(pre_q);
  assign cmp16 = 16'(cmp_q);
  assign cnt16 = 16'(cnt_q);

`ifdef TIMER_BANK_CASCADE_EN
  assign casc_rd = casc_q;
`else
  assign casc_rd = 1'b0;
`endif

  // pick this channel's tick source
  always_comb begin
    tick = src_q ? rtc_tick_i[scale_q] : core_tick_i[scale_q];
`ifdef TIMER_BANK_CASCADE_EN
    if (IDX > 0 && casc_q) tick = casc_i;
`endif
  end

  // counter, irq and register-write next state
  always_comb begin
    en_d    = en_q;
    rl_d    = 1'b0;
    os_d    = os_q;
    src_d   = src_q;
`ifdef TIMER_BANK_CASCADE_EN
    casc_d  = casc_q;
`endif
    scale_d = scale_q;
    pre_d   = pre_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    und_d   = 1'b0;
    cmpi_d  = 1'b0;
    wide    = 16'h0000;
    // pending reload wins over a tick and uses PRE before any write
    if (rl_q) begin
      cnt_d = pre_q;
    end else if (tick && en_q) begin
      if (cnt_q == '0) begin
        cnt_d = pre_q;
        und_d = 1'b1;
        if (os_q) en_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      cmpi_d = (cnt_d == cmp_q);
    end
    if (re_i && reg_i == REG_CNT_L) snap_d = cnt16[15:8];
    if (we_i) begin
      unique case (reg_i)
        REG_CTRL: begin
          en_d  = wdata_i[CTRL_EN];
          rl_d  = wdata_i[CTRL_RELOAD];
          os_d  = wdata_i[CTRL_ONESHOT];
          src_d = wdata_i[CTRL_SRC];
`ifdef TIMER_BANK_CASCADE_EN
          casc_d = wdata_i[CTRL_CASC];
`endif
        end
        REG_SCALE: scale_d = wdata_i[2:0];
        REG_PRE_L: begin
          wide = pre16;
          wide[7:0] = wdata_i;
          pre_d = wide[CNT_W-1:0];
        end
        REG_PRE_H: begin
          wide = pre16;
          wide[15:8] = wdata_i;
          pre_d = wide[CNT_W-1:0];
        end
        REG_CMP_L: begin
          wide = cmp16;
          wide[7:0] = wdata_i;
          cmp_d = wide[CNT_W-1:0];
        end
        REG_CMP_H: begin
          wide = cmp16;
          wide[15:8] = wdata_i;
          cmp_d = wide[CNT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // channel state register, advancing on clk_ce
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      rl_q    <= 1'b0;
      os_q    <= 1'b0;
      src_q   <= 1'b0;
`ifdef TIMER_BANK_CASCADE_EN
      casc_q  <= 1'b0;
`endif
      scale_q <= '0;
      pre_q   <= '0;
      cmp_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      und_q   <= 1'b0;
      cmpi_q  <= 1'b0;
    end else if (clk_ce) begin
      en_q    <= en_d;
      rl_q    <= rl_d;
      os_q    <= os_d;
      src_q   <= src_d;
`ifdef TIMER_BANK_CASCADE_EN
      casc_q  <= casc_d;
`endif
      scale_q <= scale_d;
      pre_q   <= pre_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      und_q   <= und_d;
      cmpi_q  <= cmpi_d;
    end
  end

  // register read mux
  always_comb begin
    rdata_o = 8'h00;
    unique case (reg_i)
      REG_CTRL:  rdata_o = {3'b000, casc_rd, src_q, os_q, rl_q, en_q};
      REG_SCALE: rdata_o = {5'b00000, scale_q};
      REG_PRE_L: rdata_o = pre16[7:0];
      REG_PRE_H: rdata_o = pre16[15:8];
      REG_CMP_L: rdata_o = cmp16[7:0];
      REG_CMP_H: rdata_o = cmp16[15:8];
      REG_CNT_L: rdata_o = cnt16[7:0];
      REG_CNT_H: rdata_o = snap_q;
      default:   rdata_o = 8'h00;
    endcase
  end

  assign under_o = und_q;
  assign cmp_o   = cmpi_q;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH timers sharing core and RTC prescalers.
// Define TIMER_BANK_CASCADE_EN to let channel n tick on channel n-1 underflow.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 3,
  parameter int          CNT_W     = 16,
  parameter logic [23:0] BASE_ADDR = 24'h002040
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ce,
  input  logic              rt_ce,
  input  logic              bus_write,
  input  logic              bus_read,
  input  logic [23:0]       bus_address_in,
  input  logic [7:0]        bus_data_in,
  output logic [7:0]        bus_data_out,
  output logic [NUM_CH-1:0] irq_under,
  output logic [NUM_CH-1:0] irq_cmp,
  output logic              osc256
);

  logic [11:0] psc_q, psc_d;
  logic [6:0]  rtc_q, rtc_d;
  logic [7:0]  core_tick;
  logic [7:0]  rtc_tick;
  logic [23:0] off;
  logic        hit;
  logic [NUM_CH-1:0] sel_v;
  logic [7:0]  ch_rd [NUM_CH];
`ifdef TIMER_BANK_CASCADE_EN
  logic [NUM_CH-1:0] casc_in;
  assign casc_in = NUM_CH'({irq_under, 1'b0});
`endif

  assign off = bus_address_in - BASE_ADDR;
  assign hit = (bus_address_in >= BASE_ADDR) &&
               (off < 24'(8 * NUM_CH));

  // prescaler next state: core free-running, RTC on rt_ce
  always_comb begin
    psc_d = psc_q + 12'd1;
    rtc_d = rt_ce ? rtc_q + 7'd1 : rtc_q;
  end

  // shared prescaler registers
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q <= '0;
      rtc_q <= '0;
    end else if (clk_ce) begin
      psc_q <= psc_d;
      rtc_q <= rtc_d;
    end
  end

  // divider-select ticks from the prescaler low bits
  always_comb begin
    core_tick = '0;
    rtc_tick  = '0;
    for (int s = 0; s < 8; s++) begin
      core_tick[s] = (psc_q & core_mask(3'(s))) == core_mask(3'(s));
      rtc_tick[s]  = rt_ce &&
                     ((rtc_q & rtc_mask(3'(s))) == rtc_mask(3'(s)));
    end
  end

  assign osc256 = &rtc_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic und, cmpi;
    assign sel_v[n] = hit && (off[5:3] == 3'(n));
    timer_bank_ch #(
      .CNT_W(CNT_W)
`ifdef TIMER_BANK_CASCADE_EN
      , .IDX(n)
`endif
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .clk_ce(clk_ce),
      .we_i(bus_write && sel_v[n]),
      .re_i(bus_read && sel_v[n]),
      .reg_i(off[2:0]),
      .wdata_i(bus_data_in),
      .core_tick_i(core_tick),
      .rtc_tick_i(rtc_tick),
`ifdef TIMER_BANK_CASCADE_EN
      .casc_i(casc_in[n]),
`endif
      .rdata_o(ch_rd[n]),
      .under_o(und),
      .cmp_o(cmpi)
    );
    assign irq_under[n] = und;
    assign irq_cmp[n]   = cmpi;
  end

  // read data: selected channel, zero when unmapped
  always_comb begin
    bus_data_out = 8'h00;
    for (int n = 0; n < NUM_CH; n++) begin
      if (sel_v[n]) bus_data_out = ch_rd[n];
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus random traffic checked
// against a behavioural register/counter model.
module tb_timer_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int BASE   = 'h002040;
  localparam int MAXV   = (1 << CNT_W) - 1;
  localparam int CB [8] = '{1, 3, 5, 6, 7, 8, 10, 12};

  logic clk = 1'b0;
  logic reset, clk_ce, rt_ce, bus_write, bus_read;
  logic [23:0] bus_address_in;
  logic [7:0] bus_data_in, bus_data_out;
  logic [NUM_CH-1:0] irq_under, irq_cmp;
  logic osc256;

  timer_bank #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .BASE_ADDR(24'(BASE))
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_ce(clk_ce),
    .rt_ce(rt_ce),
    .bus_write(bus_write),
    .bus_read(bus_read),
    .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out),
    .irq_under(irq_under),
    .irq_cmp(irq_cmp),
    .osc256(osc256)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] last_rd;

  int m_en[NUM_CH], m_rl[NUM_CH], m_os[NUM_CH], m_src[NUM_CH];
  int m_casc[NUM_CH], m_scale[NUM_CH], m_pre[NUM_CH], m_cmp[NUM_CH];
  int m_cnt[NUM_CH], m_snap[NUM_CH], m_und[NUM_CH], m_cmpi[NUM_CH];
  int m_psc, m_rtc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_en[n] = 0; m_rl[n] = 0; m_os[n] = 0; m_src[n] = 0;
      m_casc[n] = 0; m_scale[n] = 0; m_pre[n] = 0; m_cmp[n] = 0;
      m_cnt[n] = 0; m_snap[n] = 0; m_und[n] = 0; m_cmpi[n] = 0;
    end
    m_psc = 0;
    m_rtc = 0;
  endtask

  function automatic int m_read(int a);
    int ch, r;
    if (a < BASE || a >= BASE + 8 * NUM_CH) return 0;
    ch = (a - BASE) / 8;
    r  = (a - BASE) % 8;
    case (r)
      0: return m_en[ch] + 2 * m_rl[ch] + 4 * m_os[ch] +
                8 * m_src[ch] + 16 * m_casc[ch];
      1: return m_scale[ch];
      2: return m_pre[ch] % 256;
      3: return m_pre[ch] / 256;
      4: return m_cmp[ch] % 256;
      5: return m_cmp[ch] / 256;
      6: return m_cnt[ch] % 256;
      default: return m_snap[ch];
    endcase
  endfunction

  task automatic m_step();
    int prev[NUM_CH];
    bit ct[8], rt[8];
    int a, ch, r, d, tk, und, cm;
    bit mapped;
    if (reset) begin
      m_reset();
      return;
    end
    if (!clk_ce) return;
    for (int n = 0; n < NUM_CH; n++) prev[n] = m_und[n];
    for (int s = 0; s < 8; s++) begin
      ct[s] = (m_psc % (1 << CB[s])) == (1 << CB[s]) - 1;
      rt[s] = rt_ce && ((m_rtc % (1 << s)) == (1 << s) - 1);
    end
    a = int'(bus_address_in);
    d = int'(bus_data_in);
    mapped = (a >= BASE) && (a < BASE + 8 * NUM_CH);
    ch = mapped ? (a - BASE) / 8 : 0;
    r  = mapped ? (a - BASE) % 8 : 0;
    if (bus_read && mapped && r == 6) m_snap[ch] = m_cnt[ch] / 256;
    for (int n = 0; n < NUM_CH; n++) begin
      tk = m_src[n] ? rt[m_scale[n]] : ct[m_scale[n]];
`ifdef TIMER_BANK_CASCADE_EN
      if (n > 0 && m_casc[n] != 0) tk = prev[n - 1];
`endif
      und = 0;
      cm = 0;
      if (m_rl[n] != 0) begin
        m_cnt[n] = m_pre[n];
      end else if (tk != 0 && m_en[n] != 0) begin
        if (m_cnt[n] == 0) begin
          m_cnt[n] = m_pre[n];
          und = 1;
          if (m_os[n] != 0) m_en[n] = 0;
        end else begin
          m_cnt[n] = m_cnt[n] - 1;
        end
        cm = (m_cnt[n] == m_cmp[n]);
      end
      m_rl[n] = 0;
      m_und[n] = und;
      m_cmpi[n] = cm;
    end
    if (bus_write && mapped) begin
      case (r)
        0: begin
          m_en[ch]  = d % 2;
          m_rl[ch]  = (d / 2) % 2;
          m_os[ch]  = (d / 4) % 2;
          m_src[ch] = (d / 8) % 2;
`ifdef TIMER_BANK_CASCADE_EN
          m_casc[ch] = (d / 16) % 2;
`endif
        end
        1: m_scale[ch] = d % 8;
        2: m_pre[ch] = (m_pre[ch] / 256) * 256 + d;
        3: m_pre[ch] = (d * 256 + m_pre[ch] % 256) & MAXV;
        4: m_cmp[ch] = (m_cmp[ch] / 256) * 256 + d;
        5: m_cmp[ch] = (d * 256 + m_cmp[ch] % 256) & MAXV;
        default: ;
      endcase
    end
    m_psc = (m_psc + 1) % 4096;
    if (rt_ce) m_rtc = (m_rtc + 1) % 128;
  endtask

  task automatic cycle();
    logic [NUM_CH-1:0] eu, ec;
    #2;
    last_rd = bus_data_out;
    if (bus_read) check("rdata", bus_data_out, m_read(int'(bus_address_in)));
    @(posedge clk);
    m_step();
    #1;
    for (int n = 0; n < NUM_CH; n++) begin
      eu[n] = (m_und[n] != 0);
      ec[n] = (m_cmpi[n] != 0);
    end
    check("irq_under", irq_under, eu);
    check("irq_cmp", irq_cmp, ec);
    check("osc256", osc256, m_rtc == 127);
  endtask

  task automatic idle(int n);
    bus_write = 1'b0;
    bus_read = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic wr(int a, int d);
    bus_write = 1'b1;
    bus_read = 1'b0;
    bus_address_in = 24'(a);
    bus_data_in = 8'(d);
    cycle();
    bus_write = 1'b0;
  endtask

  task automatic rd(int a, output logic [7:0] v);
    bus_write = 1'b0;
    bus_read = 1'b1;
    bus_address_in = 24'(a);
    cycle();
    v = last_rd;
    bus_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    int t1, t2, pulses, found, a, r, d, op;
    reset = 1'b1; clk_ce = 1'b1; rt_ce = 1'b0;
    bus_write = 1'b0; bus_read = 1'b0;
    bus_address_in = '0; bus_data_in = '0;
    m_reset();
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_under", irq_under, 0);
    check("rst_osc", osc256, 0);
    for (int i = BASE - 1; i <= BASE + 8 * NUM_CH; i++) rd(i, v);

    // ch0 PRE=3, fastest core divider: underflow every 4 ticks
    wr(BASE + 2, 3);
    wr(BASE + 1, 0);
    wr(BASE + 0, 3);
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (irq_under[0]) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    check("under_period", t2 - t1, 8);
    wr(BASE + 0, 0);

    // ch1 PRE=10 CMP=5: a single compare pulse
    wr(BASE + 10, 10);
    wr(BASE + 12, 5);
    wr(BASE + 8, 3);
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      idle(1);
      if (irq_cmp[1]) pulses++;
    end
    check("cmp_pulses", pulses, 1);
    wr(BASE + 8, 0);

    // ch2 one-shot PRE=2
    wr(BASE + 18, 2);
    wr(BASE + 16, 7);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (irq_under[2]) pulses++;
    end
    check("oneshot_pulses", pulses, 1);
    rd(BASE + 16, v);
    check("oneshot_en", v[0], 0);
    rd(BASE + 22, v);
    check("oneshot_cnt", v, 2);

    // CNT_H snapshot taken on CNT_L read
    wr(BASE + 19, 1);
    wr(BASE + 18, 0);
    wr(BASE + 16, 3);
    idle(1);
    rd(BASE + 22, v);
    check("snap_cnt_l", v, 0);
    idle(4);
    rd(BASE + 23, v);
    check("snap_cnt_h", v, 1);
    rd(BASE + 22, v);
    wr(BASE + 16, 0);

    // reload strobe landing on an underflow tick
    wr(BASE + 2, 1);
    wr(BASE + 0, 1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (m_psc % 2 == 0 && m_cnt[0] == 0) found = 1;
      else idle(1);
    end
    check("rl_align", found, 1);
    wr(BASE + 0, 3);
    idle(1);
    check("rl_no_under", irq_under[0], 0);
    rd(BASE + 6, v);
    check("rl_cnt", v, 1);

    // reset in the middle of counting
    idle(3);
    reset = 1'b1;
    clk_ce = 1'b0;
    cycle();
    reset = 1'b0;
    clk_ce = 1'b1;
    check("midrst_under", irq_under, 0);
    rd(BASE + 0, v);
    check("midrst_ctrl", v, 0);
    rd(BASE + 6, v);
    check("midrst_cnt", v, 0);

`ifdef TIMER_BANK_CASCADE_EN
    // ch1 cascaded from ch0: ch1 PRE=2, ch0 PRE=1
    wr(BASE + 10, 2);
    wr(BASE + 8, 'h13);
    wr(BASE + 2, 1);
    wr(BASE + 0, 3);
    pulses = 0;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      idle(1);
      if (irq_under[0]) pulses++;
      if (irq_under[1]) found = 1;
    end
    check("casc_seen", found, 1);
    check("casc_ticks", 2 * pulses, 6);
`endif

    // random traffic against the model
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 700) == 0;
      clk_ce = ($urandom % 5) != 0;
      rt_ce = ($urandom % 3) == 0;
      op = $urandom % 4;
      a = BASE - 1 + int'($urandom_range(0, 8 * NUM_CH + 1));
      r = (a - BASE + 8) % 8;
      case (r)
        0: d = $urandom % 32;
        1: d = $urandom % 3;
        2, 4: d = $urandom % 16;
        3, 5: d = (($urandom % 8) == 0) ? $urandom % 256 : 0;
        default: d = $urandom % 256;
      endcase
      bus_write = (op == 0);
      bus_read = (op == 1);
      bus_address_in = 24'(a);
      bus_data_in = 8'(d);
      cycle();
    end
    reset = 1'b0;
    clk_ce = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, counter width per channel (8..16).
REQ-003 SHALL have parameter BASE_ADDR, default 24'h002040, start of the register window (8 bytes per channel).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports clk_ce (input, 1, core clock enable) and rt_ce (input, 1, 32768 Hz RTC enable, sampled on clk).
REQ-007 SHALL have ports bus_write, bus_read (input, 1), bus_address_in (input, 24), bus_data_in (input, 8), bus_data_out (output, 8).
REQ-008 SHALL have ports irq_under and irq_cmp (output, NUM_CH each, one per channel) and osc256 (output, 1).

Function
REQ-009 All state SHALL advance only when clk_ce=1.
REQ-010 Channel n map: BASE_ADDR+8n+{0 CTRL, 1 SCALE, 2 PRE_L, 3 PRE_H, 4 CMP_L, 5 CMP_H, 6 CNT_L, 7 CNT_H}; bits above CNT_W SHALL read 0 and ignore writes.
REQ-011 CTRL bits: [0] enable, [1] reload strobe (self-clears next cycle), [2] one-shot, [3] source (0 core, 1 RTC), [4] cascade; SCALE[2:0] divider select.
REQ-012 Writes SHALL take effect on the clk_ce cycle where bus_write=1; bus_data_out SHALL be combinational; unmapped addresses SHALL read 8'h00.
REQ-013 Shared core prescaler: 12-bit free-running; select 0..7 ticks when low 1,3,5,6,7,8,10,12 bits all ones.
REQ-014 Shared RTC prescaler: 7-bit, increments on rt_ce; select 0..7 ticks on rt_ce with low 0..7 bits all ones; osc256 SHALL be 1 when its low 7 bits are all ones.
REQ-015 On a tick with enable=1: count==0 SHALL reload PRE and pulse irq_under[n] for one clk_ce cycle; otherwise count SHALL decrement by 1.
REQ-016 irq_cmp[n] SHALL pulse one clk_ce cycle when a tick moves count to a value equal to CMP (edge event, not level).
REQ-017 One-shot: underflow SHALL also clear enable; count holds PRE.
REQ-018 Reload strobe SHALL load PRE into count and override a same-cycle tick, without any irq.
REQ-019 A same-cycle write to PRE SHALL not affect a same-cycle reload; the old PRE is used.
REQ-020 Reading CNT_L SHALL snapshot count[15:8]; CNT_H reads SHALL return the snapshot until the next CNT_L read.
REQ-021 enable=0 SHALL freeze count; irq outputs SHALL be 0 when no event.

Reset
REQ-022 On reset: all registers, counts, prescalers, snapshots 0; irq_under, irq_cmp, osc256 0; reset mid-count SHALL abort with no irq.
REQ-023 reset SHALL act regardless of clk_ce.

Configuration
REQ-024 Macro TIMER_BANK_CASCADE_EN defined: channel n>0 with cascade=1 SHALL tick on irq_under[n-1] instead of its prescaler; undefined: CTRL[4] reads 0, ignored, no cascade logic.

Structure
REQ-025 Package timer_bank_pkg SHALL hold register offsets, CTRL bit indices, and the divider-select tables.
REQ-026 Per-channel logic SHALL be sub-module timer_bank_ch, instantiated NUM_CH times via generate; prescalers stay in the top level.

Verification
REQ-027 Ch0 PRE=3, SCALE=0 core, enable -> count 3,2,1,0,3, irq_under[0] pulse every 4 ticks (8 clk_ce).
REQ-028 Ch1 PRE=10, CMP=5, enable -> exactly one irq_cmp[1] pulse as count reaches 5.
REQ-029 One-shot PRE=2 -> one irq_under, then CTRL[0] reads 0, count stays 2.
REQ-030 Count 16'h0100 -> read CNT_L (00), decrement, read CNT_H -> 01 (snapshot).
REQ-031 With TIMER_BANK_CASCADE_EN: ch0 PRE=1, ch1 cascade PRE=2 -> ch1 underflows after 6 ch0 ticks.
REQ-032 Reload strobe coincident with underflow tick -> count=PRE, no irq_under; reset mid-count -> all zero.
